// File: rtl/cla_pkg.sv
// Shared constants and helpers for the carry-lookahead adder.
// The group size is fixed at 4 bits; the word is built from whole groups.
package cla_pkg;

  localparam int CLA_GROUP = 4;

  function automatic int cla_num_groups(input int width);
    return width / CLA_GROUP;
  endfunction

endpackage

// File: rtl/cla4_block.sv
// 4-bit first-level lookahead group: sum bits plus the group propagate/generate
// consumed by the second-level carry network in the top.
module cla4_block
  import cla_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       pg,
  output logic       gg
);

  logic [3:0] p_s;
  logic [3:0] g_s;
  logic [3:0] c_s;

  // Expanded (non-rippling) carries, sum bits and group propagate/generate.
  always_comb begin
    p_s    = a ^ b;
    g_s    = a & b;
    c_s[0] = ci;
    c_s[1] = g_s[0] | (p_s[0] & ci);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & ci);
    s      = p_s ^ c_s;
    pg     = &p_s;
    gg     = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
  end

endmodule

// File: rtl/cla_adder.sv
// Registered two-level carry-lookahead adder: {cout, sum} = a + b + cin,
// one cycle of latency, outputs cleared asynchronously by rst.
module cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             pg,
  output logic             gg
);

  localparam int NG = cla_num_groups(WIDTH);

  if ((WIDTH % CLA_GROUP) != 0 || WIDTH < CLA_GROUP) begin : g_bad_width
    $error("cla_adder: WIDTH must be a positive multiple of 4");
  end

  logic [NG-1:0]    grp_pg_s;
  logic [NG-1:0]    grp_gg_s;
  logic [NG:0]      grp_c_s;
  logic [NG:0]      gen_src_s;
  logic [WIDTH-1:0] sum_s;
  logic             word_gg_s;
  logic             acc_s;
  logic             term_s;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             pg_d, pg_q;
  logic             gg_d, gg_q;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla4_block u_blk (
      .a  (a[gi*CLA_GROUP +: CLA_GROUP]),
      .b  (b[gi*CLA_GROUP +: CLA_GROUP]),
      .ci (grp_c_s[gi]),
      .s  (sum_s[gi*CLA_GROUP +: CLA_GROUP]),
      .pg (grp_pg_s[gi]),
      .gg (grp_gg_s[gi])
    );
  end

  // Second-level lookahead: carry into group k is the OR over every earlier
  // generate source (cin is source 0) ANDed with all propagates above it.
  always_comb begin
    grp_c_s   = {(NG+1){1'b0}};
    gen_src_s = {grp_gg_s, cin};
    word_gg_s = 1'b0;
    acc_s     = 1'b0;
    term_s    = 1'b0;
    for (int k = 0; k <= NG; k++) begin
      acc_s = 1'b0;
      for (int j = 0; j <= k; j++) begin
        term_s = gen_src_s[j];
        for (int m = j; m < k; m++) begin
          term_s = term_s & grp_pg_s[m];
        end
        acc_s = acc_s | term_s;
      end
      grp_c_s[k] = acc_s;
    end
    // Word generate excludes source 0 so it does not depend on cin.
    for (int j = 1; j <= NG; j++) begin
      term_s = gen_src_s[j];
      for (int m = j; m < NG; m++) begin
        term_s = term_s & grp_pg_s[m];
      end
      word_gg_s = word_gg_s | term_s;
    end
  end

  // Next-state values for the output registers.
  always_comb begin
    sum_d  = sum_s;
    cout_d = grp_c_s[NG];
    pg_d   = &grp_pg_s;
    gg_d   = word_gg_s;
  end

  // Output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= {WIDTH{1'b0}};
      cout_q <= 1'b0;
      pg_q   <= 1'b0;
      gg_q   <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      pg_q   <= pg_d;
      gg_q   <= gg_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign pg   = pg_q;
  assign gg   = gg_q;

endmodule

// File: tb/tb_cla_adder.sv
// Self-checking bench for cla_adder at WIDTH 4 and 16 against an arithmetic
// reference model, plus directed literal expectations.
module tb_cla_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  a4, b4, sum4;
  logic        cin4, cout4, pg4, gg4;
  logic [15:0] a16, b16, sum16;
  logic        cin16, cout16, pg16, gg16;

  int n_checks = 0;
  int n_fail   = 0;

  cla_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4),
    .sum(sum4), .cout(cout4), .pg(pg4), .gg(gg4)
  );

  cla_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16),
    .sum(sum16), .cout(cout16), .pg(pg16), .gg(gg16)
  );

  // Reference result packed as {gg, pg, cout, sum[15:0]}.
  function automatic logic [18:0] ref_add(input int w, input logic [15:0] x,
                                          input logic [15:0] y, input logic c);
    longint full, noc, mask, xv, yv;
    logic [18:0] r;
    xv   = longint'(x);
    yv   = longint'(y);
    mask = (64'sd1 <<< w) - 64'sd1;
    full = xv + yv + (c ? 64'sd1 : 64'sd0);
    noc  = xv + yv;
    r        = 19'd0;
    r[15:0]  = 16'(full & mask);
    r[16]    = ((full >>> w) & 64'sd1) != 64'sd0;
    r[17]    = ((xv ^ yv) & mask) == mask;
    r[18]    = ((noc >>> w) & 64'sd1) != 64'sd0;
    return r;
  endfunction

  logic [18:0] exp4_q  = 19'd0;
  logic [18:0] exp16_q = 19'd0;

  // Model of the registered outputs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp4_q  <= 19'd0;
      exp16_q <= 19'd0;
    end else begin
      exp4_q  <= ref_add(4, {12'd0, a4}, {12'd0, b4}, cin4);
      exp16_q <= ref_add(16, a16, b16, cin16);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare every cycle, away from the rising edge.
  always @(negedge clk) begin
    check("sum4",   32'(sum4),   32'(exp4_q[3:0]));
    check("cout4",  32'(cout4),  32'(exp4_q[16]));
    check("pg4",    32'(pg4),    32'(exp4_q[17]));
    check("gg4",    32'(gg4),    32'(exp4_q[18]));
    check("sum16",  32'(sum16),  32'(exp16_q[15:0]));
    check("cout16", 32'(cout16), 32'(exp16_q[16]));
    check("pg16",   32'(pg16),   32'(exp16_q[17]));
    check("gg16",   32'(gg16),   32'(exp16_q[18]));
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_sum4"},   32'(sum4),   32'd0);
    check({tag, "_cout4"},  32'(cout4),  32'd0);
    check({tag, "_pg4"},    32'(pg4),    32'd0);
    check({tag, "_gg4"},    32'(gg4),    32'd0);
    check({tag, "_sum16"},  32'(sum16),  32'd0);
    check({tag, "_cout16"}, 32'(cout16), 32'd0);
  endtask

  task automatic apply4(input logic [3:0] x, input logic [3:0] y, input logic c,
                        input logic [3:0] es, input logic ec);
    @(negedge clk);
    a4 = x; b4 = y; cin4 = c;
    @(posedge clk);
    #1;
    check("dir_sum4",  32'(sum4),  32'(es));
    check("dir_cout4", 32'(cout4), 32'(ec));
  endtask

  initial begin
    a4 = 4'd5; b4 = 4'd9; cin4 = 1'b0;
    a16 = 16'd0; b16 = 16'd0; cin16 = 1'b0;

    // Asynchronous reset, then first capture after release.
    #1 rst = 1'b1;
    #1 check_all_zero("rst");
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_sum4",  32'(sum4),  32'd14);
    check("post_rst_cout4", 32'(cout4), 32'd0);

    apply4(4'd0,  4'd0,  1'b0, 4'd0,  1'b0);
    apply4(4'd8,  4'd1,  1'b1, 4'd10, 1'b0);
    apply4(4'd10, 4'd11, 1'b0, 4'd5,  1'b1);
    apply4(4'd5,  4'd9,  1'b0, 4'd14, 1'b0);
    apply4(4'd2,  4'd7,  1'b1, 4'd10, 1'b0);
    apply4(4'd15, 4'd15, 1'b1, 4'd15, 1'b1);

    apply4(4'b1010, 4'b0101, 1'b1, 4'd0, 1'b1);
    check("chain_pg4", 32'(pg4), 32'd1);
    check("chain_gg4", 32'(gg4), 32'd0);
    apply4(4'b1010, 4'b0101, 1'b0, 4'd15, 1'b0);

    // Exhaustive 4-bit space, back to back.
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      a4   = 4'(i);
      b4   = 4'(i >> 4);
      cin4 = 1'(i >> 8);
    end

    // Random stream on both widths with one mid-stream reset pulse.
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      a4    = 4'($urandom);
      b4    = 4'($urandom);
      cin4  = 1'($urandom);
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      cin16 = 1'($urandom);
      if (n == 5000) begin
        #2 rst = 1'b1;
        #1 check_all_zero("mid_rst");
        #1 rst = 1'b0;
      end
    end

    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1;
    @(posedge clk);
    #1;
    check("max16_sum",  32'(sum16),  32'd0);
    check("max16_cout", 32'(cout16), 32'd1);
    check("max16_pg",   32'(pg16),   32'd1);
    check("max16_gg",   32'(gg16),   32'd0);

    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;
    @(posedge clk);
    #1;
    check("ones16_sum",  32'(sum16),  32'hFFFF);
    check("ones16_cout", 32'(cout16), 32'd1);
    check("ones16_gg",   32'(gg16),   32'd1);

    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
